// File: rtl/unidad_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply or
// restoring divide, one-cycle write strobe toward the register file.
module unidad_muldiv #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, stateNext;

  logic [CW-1:0]     cnt;
  logic [2:0]        fnQ;
  logic [4:0]        rdQ;
  logic [XLEN-1:0]   opr;
  logic [2*XLEN-1:0] acc;
  logic              negQ;
  logic              spcQ;
  logic [XLEN-1:0]   spcVQ;

  logic              accept;
  logic              lastIter;
  logic              isMul;
  logic              aSgn;
  logic              bSgn;
  logic              aNeg;
  logic              bNeg;
  logic [XLEN-1:0]   magA;
  logic [XLEN-1:0]   magB;
  logic              negIn;
  logic              divZero;
  logic              ovf;
  logic [XLEN-1:0]   spcVal;

  logic [XLEN:0]     mulSum;
  logic [XLEN:0]     divTry;
  logic [2*XLEN-1:0] accMul;
  logic [2*XLEN-1:0] accDiv;
  logic [2*XLEN-1:0] accNext;
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   finalRes;

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  // DONE's exit edge may already accept the next op (33-cycle throughput)
  assign accept   = start && (state != CALC);
  assign lastIter = (state == CALC) && (cnt == CW'(ITER - 1));

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = CALC;
      CALC:    if (lastIter) stateNext = DONE;
      DONE:    stateNext = start ? CALC : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    isMul = ~funct3[2];
    aSgn  = 1'b0;
    bSgn  = 1'b0;
    case (funct3)
      3'b001: begin aSgn = 1'b1; bSgn = 1'b1; end
      3'b010: aSgn = 1'b1;
      3'b100: begin aSgn = 1'b1; bSgn = 1'b1; end
      3'b110: begin aSgn = 1'b1; bSgn = 1'b1; end
      default: ;
    endcase
    aNeg    = aSgn & op_a[XLEN-1];
    bNeg    = bSgn & op_b[XLEN-1];
    magA    = aNeg ? -op_a : op_a;
    magB    = bNeg ? -op_b : op_b;
    negIn   = (funct3 == 3'b110) ? aNeg : (aNeg ^ bNeg);
    divZero = funct3[2] & (op_b == '0);
    ovf     = funct3[2] & ~funct3[0]
            & (op_a == {1'b1, {(XLEN-1){1'b0}}})
            & (op_b == '1);
    spcVal  = '0;
    if (divZero) spcVal = funct3[1] ? op_a : '1;
    else if (!funct3[1]) spcVal = {1'b1, {(XLEN-1){1'b0}}};
  end

  always_comb begin
    mulSum  = {1'b0, acc[2*XLEN-1:XLEN]}
            + (acc[0] ? {1'b0, opr} : '0);
    accMul  = {mulSum, acc[XLEN-1:1]};
    divTry  = acc[2*XLEN-1:XLEN-1] - {1'b0, opr};
    // restoring step: keep the shifted remainder when the trial underflows
    accDiv  = divTry[XLEN]
            ? {acc[2*XLEN-2:0], 1'b0}
            : {divTry[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    accNext = fnQ[2] ? accDiv : accMul;
    prodFix = negQ ? -accNext : accNext;
    quo     = accNext[XLEN-1:0];
    rem     = accNext[2*XLEN-1:XLEN];
    if (negQ) begin
      quo = -quo;
      rem = -rem;
    end
    if (spcQ)                finalRes = spcVQ;
    else if (fnQ[2])         finalRes = fnQ[1] ? rem : quo;
    else if (fnQ[1:0] == '0) finalRes = prodFix[XLEN-1:0];
    else                     finalRes = prodFix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt    <= '0;
      fnQ    <= '0;
      rdQ    <= '0;
      opr    <= '0;
      acc    <= '0;
      negQ   <= 1'b0;
      spcQ   <= 1'b0;
      spcVQ  <= '0;
      result <= '0;
      rd_out <= '0;
    end else if (accept) begin
      cnt   <= '0;
      fnQ   <= funct3;
      rdQ   <= rd_in;
      opr   <= isMul ? magA : magB;
      acc   <= {{XLEN{1'b0}}, isMul ? magB : magA};
      negQ  <= negIn;
      spcQ  <= divZero | ovf;
      spcVQ <= spcVal;
    end else if (state == CALC) begin
      acc <= accNext;
      cnt <= cnt + 1'b1;
      if (lastIter) begin
        result <= finalRes;
        rd_out <= rdQ;
      end
    end
  end

endmodule
